// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: bus command encodings,
// tag width, owner-table entry layout and a saturating counter helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int MEM_TAG_W = 4;
  localparam int CNT_W     = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd16;

  // owner: 1 = dcache, 0 = icache
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_owner_t;

  // Simultaneous inc and dec cancel; saturates at 0 and CNT_MAX.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec && c != CNT_MAX) n = c + 1'b1;
    if (dec && !inc && c != '0)      n = c - 1'b1;
    return n;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side and memory-side bus of the arbiter. master = requesters/memory
// model driving the arbiter, slave = the arbiter itself.
interface mem_arbiter_if #(parameter int XLEN = 32) ();
  import mem_arbiter_pkg::*;

  logic [1:0]           proc2Imem_command;
  logic [XLEN-1:0]      proc2Imem_addr;
  logic [MEM_TAG_W-1:0] Imem2proc_response;
  logic [63:0]          Imem2proc_data;
  logic [MEM_TAG_W-1:0] Imem2proc_tag;

  logic [1:0]           dcache2mem_command;
  logic [XLEN-1:0]      dcache2mem_addr;
  logic [63:0]          dcache2mem_data;
  logic [MEM_TAG_W-1:0] mem2dcache_response;
  logic [63:0]          mem2dcache_data;
  logic [MEM_TAG_W-1:0] mem2dcache_tag;

  logic [1:0]           mem_command;
  logic [XLEN-1:0]      mem_addr;
  logic [63:0]          mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [63:0]          mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    input  mem2dcache_response, mem2dcache_data, mem2dcache_tag,
    input  mem_command, mem_addr, mem_data
  );

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    output mem2dcache_response, mem2dcache_data, mem2dcache_tag,
    output mem_command, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_arbiter_tag_table.sv
// Owner table: one {valid, owner} entry per memory tag. Tag 0 is never
// allocated; allocation overrides a free of the same tag at the same edge.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  logic                 alloc_owner,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output tag_owner_t           lookup_entry,
  input  logic                 free_en,
  input  logic [MEM_TAG_W-1:0] free_tag
);

  tag_owner_t [NUM_TAGS-1:0] owner_q, owner_d;

  always_comb begin
    owner_d = owner_q;
    if (free_en) owner_d[free_tag] = '0;
    if (alloc_en && alloc_tag != '0) owner_d[alloc_tag] = '{valid: 1'b1, owner: alloc_owner};
  end

  always_ff @(posedge clock) begin
    if (reset) owner_q <= '0;
    else       owner_q <= owner_d;
  end

  assign lookup_entry = owner_q[lookup_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Stateful icache/dcache arbiter for the single memory port: dcache priority
// with an anti-starvation override, and tag-owner based return routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  mem_arbiter_if.slave     bus,
  output logic             grant_dcache,
  output logic [CNT_W-1:0] outstanding_i,
  output logic [CNT_W-1:0] outstanding_d,
  output logic             orphan_tag_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] out_i_q, out_i_d, out_d_q, out_d_d;
  logic             orphan_q, orphan_d;

  logic             icache_req, dcache_req, alloc_en, ret_valid;
  logic [XLEN-1:0]  addr_sel;
  tag_owner_t       ret_entry;

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (bus.mem2proc_response),
    .alloc_owner (grant_dcache),
    .lookup_tag  (bus.mem2proc_tag),
    .lookup_entry(ret_entry),
    .free_en     (ret_valid),
    .free_tag    (bus.mem2proc_tag)
  );

  always_comb begin
    icache_req   = bus.proc2Imem_command != BUS_NONE;
    dcache_req   = bus.dcache2mem_command != BUS_NONE;
    // Once the icache has waited STARVE_LIMIT dcache grants it takes the port.
    grant_dcache = dcache_req && !(icache_req && starve_cnt_q == SW'(STARVE_LIMIT));

    bus.mem_command = grant_dcache ? bus.dcache2mem_command : bus.proc2Imem_command;
    addr_sel        = grant_dcache ? bus.dcache2mem_addr    : bus.proc2Imem_addr;
    bus.mem_addr    = addr_sel;
    bus.mem_data    = bus.dcache2mem_data;

    bus.mem2dcache_response = grant_dcache ? bus.mem2proc_response : '0;
    bus.Imem2proc_response  = grant_dcache ? '0 : bus.mem2proc_response;

    alloc_en  = bus.mem_command == BUS_LOAD && bus.mem2proc_response != '0;
    ret_valid = bus.mem2proc_tag != '0 && ret_entry.valid;

    bus.mem2dcache_tag  = '0;
    bus.mem2dcache_data = '0;
    bus.Imem2proc_tag   = '0;
    bus.Imem2proc_data  = '0;
    if (ret_valid && ret_entry.owner) begin
      bus.mem2dcache_tag  = bus.mem2proc_tag;
      bus.mem2dcache_data = bus.mem2proc_data;
    end else if (ret_valid) begin
      bus.Imem2proc_tag  = bus.mem2proc_tag;
      bus.Imem2proc_data = bus.mem2proc_data;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (icache_req && grant_dcache) starve_cnt_d = starve_cnt_q + 1'b1;
    out_i_d  = cnt_next(out_i_q, alloc_en && !grant_dcache, ret_valid && !ret_entry.owner);
    out_d_d  = cnt_next(out_d_q, alloc_en &&  grant_dcache, ret_valid &&  ret_entry.owner);
    orphan_d = orphan_q || (bus.mem2proc_tag != '0 && !ret_entry.valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      out_i_q      <= '0;
      out_d_q      <= '0;
      orphan_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      out_i_q      <= out_i_d;
      out_d_q      <= out_d_d;
      orphan_q     <= orphan_d;
    end
  end

  assign outstanding_i  = out_i_q;
  assign outstanding_d  = out_d_q;
  assign orphan_tag_err = orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge,
// combinational outputs are checked 1ns later, registered ones a cycle later.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clock, reset;
  logic       grant_dcache, orphan_tag_err;
  logic [4:0] outstanding_i, outstanding_d;
  int         n_pass, n_total;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .grant_dcache  (grant_dcache),
    .outstanding_i (outstanding_i),
    .outstanding_d (outstanding_d),
    .orphan_tag_err(orphan_tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.proc2Imem_command  = BUS_NONE;
    bus.proc2Imem_addr     = '0;
    bus.dcache2mem_command = BUS_NONE;
    bus.dcache2mem_addr    = '0;
    bus.dcache2mem_data    = '0;
    bus.mem2proc_response  = '0;
    bus.mem2proc_data      = '0;
    bus.mem2proc_tag       = '0;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic exp_g [10];
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n_pass = 0;
    n_total = 0;

    // reset state
    idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("rst_out_i", outstanding_i, 0);
    chk("rst_out_d", outstanding_d, 0);
    chk("rst_orphan", orphan_tag_err, 0);
    chk("rst_grant", grant_dcache, 0);
    chk("rst_mem_cmd", bus.mem_command, BUS_NONE);
    reset = 1'b0;

    // icache-only load, tag 3, return 0xDEAD
    bus.proc2Imem_command = BUS_LOAD;
    bus.proc2Imem_addr    = 32'h100;
    bus.mem2proc_response = 4'd3;
    #1;
    chk("i_resp", bus.Imem2proc_response, 3);
    chk("i_d_resp", bus.mem2dcache_response, 0);
    chk("i_mem_cmd", bus.mem_command, BUS_LOAD);
    chk("i_mem_addr", bus.mem_addr, 32'h100);
    chk("i_grant", grant_dcache, 0);
    @(negedge clock);
    chk("i_out_1", outstanding_i, 1);
    idle();
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = 64'hDEAD;
    #1;
    chk("i_ret_tag", bus.Imem2proc_tag, 3);
    chk("i_ret_data", bus.Imem2proc_data, 64'hDEAD);
    chk("i_ret_dtag", bus.mem2dcache_tag, 0);
    chk("i_ret_ddata", bus.mem2dcache_data, 0);
    @(negedge clock);
    idle();
    chk("i_out_0", outstanding_i, 0);

    // both request every cycle: 4 dcache grants, then 1 icache grant
    for (int i = 0; i < 10; i++) begin
      bus.proc2Imem_command  = BUS_LOAD;
      bus.proc2Imem_addr     = 32'h1000 + 32'(i);
      bus.dcache2mem_command = BUS_LOAD;
      bus.dcache2mem_addr    = 32'h2000 + 32'(i);
      bus.mem2proc_response  = 4'(i + 1);
      #1;
      chk($sformatf("starve_grant_%0d", i), grant_dcache, exp_g[i]);
      if (exp_g[i]) chk($sformatf("starve_dresp_%0d", i), bus.mem2dcache_response, 64'(i + 1));
      else          chk($sformatf("starve_iresp_%0d", i), bus.Imem2proc_response, 64'(i + 1));
      @(negedge clock);
    end
    idle();
    chk("starve_out_d", outstanding_d, 8);
    chk("starve_out_i", outstanding_i, 2);
    pulse_reset();

    // store accepted as tag 5 allocates nothing; its return is an orphan
    bus.dcache2mem_command = BUS_STORE;
    bus.dcache2mem_addr    = 32'h200;
    bus.dcache2mem_data    = 64'h1234_5678_9ABC_DEF0;
    bus.mem2proc_response  = 4'd5;
    #1;
    chk("st_mem_cmd", bus.mem_command, BUS_STORE);
    chk("st_mem_data", bus.mem_data, 64'h1234_5678_9ABC_DEF0);
    chk("st_dresp", bus.mem2dcache_response, 5);
    @(negedge clock);
    chk("st_out_d", outstanding_d, 0);
    idle();
    bus.mem2proc_tag  = 4'd5;
    bus.mem2proc_data = 64'h55;
    #1;
    chk("st_ret_dtag", bus.mem2dcache_tag, 0);
    chk("st_ret_itag", bus.Imem2proc_tag, 0);
    @(negedge clock);
    idle();
    chk("st_orphan", orphan_tag_err, 1);
    @(negedge clock);
    chk("st_orphan_sticky", orphan_tag_err, 1);
    pulse_reset();
    chk("st_orphan_clr", orphan_tag_err, 0);

    // tag 7 returns to icache while being re-accepted for dcache
    bus.proc2Imem_command = BUS_LOAD;
    bus.proc2Imem_addr    = 32'h700;
    bus.mem2proc_response = 4'd7;
    #1;
    chk("re_iresp", bus.Imem2proc_response, 7);
    @(negedge clock);
    idle();
    bus.dcache2mem_command = BUS_LOAD;
    bus.dcache2mem_addr    = 32'h704;
    bus.mem2proc_response  = 4'd7;
    bus.mem2proc_tag       = 4'd7;
    bus.mem2proc_data      = 64'hBEEF;
    #1;
    chk("re_itag", bus.Imem2proc_tag, 7);
    chk("re_idata", bus.Imem2proc_data, 64'hBEEF);
    chk("re_dtag", bus.mem2dcache_tag, 0);
    chk("re_dresp", bus.mem2dcache_response, 7);
    @(negedge clock);
    chk("re_out_i", outstanding_i, 0);
    chk("re_out_d", outstanding_d, 1);
    idle();
    bus.mem2proc_tag  = 4'd7;
    bus.mem2proc_data = 64'hCAFE;
    #1;
    chk("re2_dtag", bus.mem2dcache_tag, 7);
    chk("re2_ddata", bus.mem2dcache_data, 64'hCAFE);
    chk("re2_itag", bus.Imem2proc_tag, 0);
    @(negedge clock);
    idle();
    chk("re2_out_d", outstanding_d, 0);
    chk("re2_orphan", orphan_tag_err, 0);

    // memory refuses (response 0), request held and accepted as tag 2
    bus.dcache2mem_command = BUS_LOAD;
    bus.dcache2mem_addr    = 32'h300;
    #1;
    chk("nak_grant", grant_dcache, 1);
    chk("nak_dresp", bus.mem2dcache_response, 0);
    @(negedge clock);
    chk("nak_out_d", outstanding_d, 0);
    bus.mem2proc_response = 4'd2;
    #1;
    chk("acc_dresp", bus.mem2dcache_response, 2);
    @(negedge clock);
    chk("acc_out_d", outstanding_d, 1);

    // three more dcache loads, then reset mid-flight
    bus.mem2proc_response = 4'd1;
    @(negedge clock);
    bus.mem2proc_response = 4'd3;
    @(negedge clock);
    bus.mem2proc_response = 4'd4;
    @(negedge clock);
    chk("mid_out_d", outstanding_d, 4);
    pulse_reset();
    chk("mid_rst_out_d", outstanding_d, 0);
    chk("mid_rst_orphan", orphan_tag_err, 0);
    bus.mem2proc_tag  = 4'd1;
    bus.mem2proc_data = 64'h11;
    #1;
    chk("late_dtag", bus.mem2dcache_tag, 0);
    chk("late_itag", bus.Imem2proc_tag, 0);
    @(negedge clock);
    idle();
    chk("late_orphan", orphan_tag_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
